ctta_acc_pipe: RTL

//   Registered, parametrised add/subtract/accumulate unit; sequential successor of the combinational CTTA adder.

---
 rtl/ctta_pkg.sv | 19 +
 rtl/ctta_addsub.sv | 38 +++
 rtl/ctta_acc_pipe.sv | 110 +++++++++++
 3 files changed

// File: rtl/ctta_pkg.sv
// ============================================================================
// Module : ctta_pkg
// Brief  : Shared operation encoding for the CTTA accumulate pipeline.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ctta_pkg;

  typedef enum logic [1:0] {
    OP_ADD     = 2'b00,
    OP_SUB     = 2'b01,
    OP_ACC_ADD = 2'b10,
    OP_ACC_SUB = 2'b11
  } ctta_op_t;

endpackage

`default_nettype wire

// File: rtl/ctta_addsub.sv
// ============================================================================
// Module : ctta_addsub
// Brief  : Combinational WR-bit add/sub with carry/borrow out; CTTA_SAT_EN
//          clamps a wrapped result to 0 (borrow) or all-ones (carry).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ctta_addsub #(
  parameter int WR = 5
) (
  input  logic [WR-1:0] i_x,
  input  logic [WR-1:0] i_y,
  input  logic          i_sub,
  output logic [WR-1:0] o_res,
  output logic          o_flag
);

  logic [WR:0] w_sum;

  // The extra top bit is the carry on add and the borrow on subtract.
  assign w_sum  = i_sub ? ({1'b0, i_x} - {1'b0, i_y}) : ({1'b0, i_x} + {1'b0, i_y});
  assign o_flag = w_sum[WR];

`ifdef CTTA_SAT_EN
  always_comb begin
    o_res = w_sum[WR-1:0];
    if (w_sum[WR]) begin
      o_res = i_sub ? '0 : '1;
    end
  end
`else
  assign o_res = w_sum[WR-1:0];
`endif

endmodule

`default_nettype wire

// File: rtl/ctta_acc_pipe.sv
// ============================================================================
// Module : ctta_acc_pipe
// Brief  : Registered add/sub/accumulate unit with valid/ready handshake,
//          overflow flag and saturating accumulate-op counter.
//          Optional macro CTTA_SAT_EN selects saturating arithmetic.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ctta_acc_pipe
  import ctta_pkg::*;
#(
  parameter int W     = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [W-1:0]     A,
  input  logic [W-1:0]     B,
  input  logic [W-1:0]     C,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W:0]       q,
  output logic             ovf,
  output logic [CNT_W-1:0] acc_cnt
);

  ctta_op_t         w_op;
  logic [W:0]       w_x;
  logic [W:0]       w_y;
  logic             w_sub;
  logic [W:0]       w_res;
  logic             w_flag;
  logic             w_accept;
  logic             w_in_ready;

  logic [W:0]       r_acc;
  logic [W:0]       r_q;
  logic             r_ovf;
  logic             r_out_valid;
  logic [CNT_W-1:0] r_acc_cnt;

  assign w_op       = ctta_op_t'(op);
  assign w_in_ready = !clr && (!r_out_valid || out_ready);
  assign w_accept   = in_valid && w_in_ready;

  always_comb begin
    w_x   = {1'b0, A};
    w_y   = {1'b0, B};
    w_sub = 1'b0;
    case (w_op)
      OP_ADD:     begin w_x = {1'b0, A}; w_y = {1'b0, B}; w_sub = 1'b0; end
      OP_SUB:     begin w_x = {1'b0, A}; w_y = {1'b0, C}; w_sub = 1'b1; end
      OP_ACC_ADD: begin w_x = r_acc;     w_y = {1'b0, A}; w_sub = 1'b0; end
      OP_ACC_SUB: begin w_x = r_acc;     w_y = {1'b0, C}; w_sub = 1'b1; end
      default:    begin w_x = {1'b0, A}; w_y = {1'b0, B}; w_sub = 1'b0; end
    endcase
  end

  ctta_addsub #(
    .WR (W + 1)
  ) u_addsub (
    .i_x    (w_x),
    .i_y    (w_y),
    .i_sub  (w_sub),
    .o_res  (w_res),
    .o_flag (w_flag)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_q         <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_acc_cnt   <= '0;
    end else if (clr) begin
      r_acc       <= '0;
      r_q         <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_acc_cnt   <= '0;
    end else if (w_accept) begin
      r_q         <= w_res;
      r_ovf       <= (w_op == OP_ADD) ? 1'b0 : w_flag;
      r_out_valid <= 1'b1;
      if (w_op == OP_ACC_ADD || w_op == OP_ACC_SUB) begin
        r_acc <= w_res;
        if (r_acc_cnt != {CNT_W{1'b1}}) begin
          r_acc_cnt <= r_acc_cnt + 1'b1;
        end
      end
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign q         = r_q;
  assign ovf       = r_ovf;
  assign acc_cnt   = r_acc_cnt;

endmodule

`default_nettype wire
